// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and SPI mode encoding for the SPI master shifter.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] SPI_MODE0 = 2'd0;
   localparam logic [1:0] SPI_MODE1 = 2'd1;
   localparam logic [1:0] SPI_MODE2 = 2'd2;
   localparam logic [1:0] SPI_MODE3 = 2'd3;

   localparam int CPHA_BIT = 0;
   localparam int CPOL_BIT = 1;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: parallel-load shift register; MSB_FIRST picks which end is serial out,
// and serial in enters at the opposite end so a full word lands in natural bit order.
module spi_shift_reg #(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              shift_en,
   input  logic              serial_in,
   output logic              serial_out,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift_en) begin
         if (MSB_FIRST) q <= {q[DATA_W-2:0], serial_in};
         else           q <= {serial_in, q[DATA_W-1:1]};
      end
   end

   assign serial_out = MSB_FIRST ? q[DATA_W-1] : q[0];

endmodule

// File: rtl/spi_m_shift.sv
// spi_m_shift: SPI master data path driven by the clock generator's edge strobes.
// Define SPI_M_LOOPBACK_EN to add i_loopback (RX samples MOSI, slave stays deselected).
module spi_m_shift
   import spi_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_mode,
   input  logic              i_tx_valid,
   input  logic [DATA_W-1:0] i_tx_data,
   output logic              o_tx_ready,
   input  logic              i_leading_edge,
   input  logic              i_trailing_edge,
   input  logic              i_miso,
`ifdef SPI_M_LOOPBACK_EN
   input  logic              i_loopback,
`endif
   output logic              o_mosi,
   output logic              o_ss_n,
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   output logic              o_busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t           state, state_nxt;
   logic [1:0]       mode_q;
   logic             cpha;
   logic             unused_cpol;
   logic             lpbk_in, lpbk_q;
   logic [CNT_W-1:0] bit_cnt;
   logic             mosi_en;
   logic             accept;
   logic             lead, trail;
   logic             tx_shift, rx_shift, cnt_inc, drive_first;
   logic             tx_sout, sample_bit;
   logic [DATA_W-1:0] rx_q;
   logic [DATA_W-1:0] tx_q_unused;
   logic             rx_sout_unused;

`ifdef SPI_M_LOOPBACK_EN
   assign lpbk_in = i_loopback;
`else
   assign lpbk_in = 1'b0;
`endif

   assign accept      = i_tx_valid & o_tx_ready;
   assign cpha        = mode_q[CPHA_BIT];
   assign unused_cpol = mode_q[CPOL_BIT];
   // A trailing strobe coinciding with a leading one is an upstream error; drop it.
   assign lead  = i_leading_edge;
   assign trail = i_trailing_edge & ~i_leading_edge;

   assign o_tx_ready = (state == IDLE);
   assign o_mosi     = (state == SHIFT) & mosi_en & tx_sout;
   assign sample_bit = lpbk_q ? o_mosi : i_miso;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      tx_shift    = 1'b0;
      rx_shift    = 1'b0;
      cnt_inc     = 1'b0;
      drive_first = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (!cpha) begin
               if (lead) begin
                  if (bit_cnt < CNT_FULL) begin
                     rx_shift = 1'b1;
                     cnt_inc  = 1'b1;
                  end
               end else if (trail) begin
                  if (bit_cnt < CNT_FULL) tx_shift  = 1'b1;
                  else                    state_nxt = DONE;
               end
            end else begin
               // First leading strobe exposes the already-loaded first bit.
               if (lead) begin
                  if (mosi_en) tx_shift    = 1'b1;
                  else         drive_first = 1'b1;
               end else if (trail) begin
                  rx_shift = 1'b1;
                  cnt_inc  = 1'b1;
                  if (bit_cnt == CNT_LAST) state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mode_q     <= '0;
         lpbk_q     <= 1'b0;
         bit_cnt    <= '0;
         mosi_en    <= 1'b0;
         o_ss_n     <= 1'b1;
         o_busy     <= 1'b0;
         o_rx_data  <= '0;
         o_rx_valid <= 1'b0;
      end else begin
         o_rx_valid <= (state == DONE);
         if (accept) begin
            mode_q  <= i_mode;
            lpbk_q  <= lpbk_in;
            bit_cnt <= '0;
            mosi_en <= ~i_mode[CPHA_BIT];
            o_ss_n  <= lpbk_in;
            o_busy  <= 1'b1;
         end else begin
            if (cnt_inc)     bit_cnt <= bit_cnt + CNT_W'(1);
            if (drive_first) mosi_en <= 1'b1;
         end
         if (state == DONE) begin
            o_rx_data <= rx_q;
            o_ss_n    <= 1'b1;
            o_busy    <= 1'b0;
            mosi_en   <= 1'b0;
         end
      end
   end

   spi_shift_reg #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_tx_sr (
      .clk        (i_clk),
      .rst        (i_rst),
      .load       (accept),
      .load_data  (i_tx_data),
      .shift_en   (tx_shift),
      .serial_in  (1'b0),
      .serial_out (tx_sout),
      .q          (tx_q_unused)
   );

   spi_shift_reg #(.DATA_W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_rx_sr (
      .clk        (i_clk),
      .rst        (i_rst),
      .load       (accept),
      .load_data  ('0),
      .shift_en   (rx_shift),
      .serial_in  (sample_bit),
      .serial_out (rx_sout_unused),
      .q          (rx_q)
   );

endmodule

// File: tb/tb_spi_m_shift.sv
// tb_spi_m_shift: drives an MSB-first and an LSB-first instance in lockstep with
// edge strobes and slave models; checks streams, received words and handshake timing.
module tb_spi_m_shift;
   import spi_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          tx_valid = 1'b0;
   logic          lead = 1'b0, trail = 1'b0;
   logic [1:0]    mode = '0;
   logic [W-1:0]  tx_data = '0;
   logic [1:0]    miso = '0;
   logic [1:0]    tx_ready, mosi, ss_n, rx_valid, busy;
   logic [W-1:0]  rx_data [2];
   logic          lb = 1'b0;

   int checks = 0;
   int errors = 0;
   int vcnt [2] = '{0, 0};

   spi_m_shift #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
      .o_tx_ready(tx_ready[0]), .i_leading_edge(lead), .i_trailing_edge(trail), .i_miso(miso[0]),
`ifdef SPI_M_LOOPBACK_EN
      .i_loopback(lb),
`endif
      .o_mosi(mosi[0]), .o_ss_n(ss_n[0]), .o_rx_data(rx_data[0]), .o_rx_valid(rx_valid[0]),
      .o_busy(busy[0])
   );

   spi_m_shift #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_tx_valid(tx_valid), .i_tx_data(tx_data),
      .o_tx_ready(tx_ready[1]), .i_leading_edge(lead), .i_trailing_edge(trail), .i_miso(miso[1]),
`ifdef SPI_M_LOOPBACK_EN
      .i_loopback(lb),
`endif
      .o_mosi(mosi[1]), .o_ss_n(ss_n[1]), .o_rx_data(rx_data[1]), .o_rx_valid(rx_valid[1]),
      .o_busy(busy[1])
   );

   always @(posedge clk) begin
      if (rx_valid[0]) vcnt[0] <= vcnt[0] + 1;
      if (rx_valid[1]) vcnt[1] <= vcnt[1] + 1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Bit k of the serial stream: d=0 is the MSB-first instance, d=1 the LSB-first one.
   function automatic logic sbit(input logic [W-1:0] w, input int k, input int d);
      if (lb) return 1'($urandom);
      return (d == 1) ? w[k] : w[W-1-k];
   endfunction

   task automatic xfer(input logic [1:0] md, input logic [W-1:0] tx, input logic [W-1:0] slv,
                       input logic [W-1:0] exp_rx, input bit poke, input bit both,
                       input int abort_k);
      logic [W-1:0] seen [2];
      int v0 [2];
      int n;
      bit cpha;
      cpha = md[CPHA_BIT];
      n = 0;
      while (tx_ready !== 2'b11 && n < 50) begin
         tick;
         n++;
      end
      chk("ready_before_accept", tx_ready, 2'b11);
      v0[0] = vcnt[0];
      v0[1] = vcnt[1];
      mode = md; tx_data = tx; tx_valid = 1'b1;
      for (int d = 0; d < 2; d++) miso[d] = cpha ? 1'b0 : sbit(slv, 0, d);
      tick;
      tx_valid = 1'b0; tx_data = W'($urandom); mode = 2'($urandom);
      chk("accept_busy", busy, 2'b11);
      chk("accept_ss_n", ss_n, lb ? 2'b11 : 2'b00);
      chk("accept_tx_ready", tx_ready, 2'b00);
      if (cpha) chk("cpha1_mosi_before_lead", mosi, 2'b00);
      seen[0] = '0;
      seen[1] = '0;
      for (int k = 0; k < W; k++) begin
         repeat ($urandom_range(0, 2)) tick;
         lead = 1'b1;
         if (both && k == 2) trail = 1'b1;
         if (poke && k == 3) begin
            tx_valid = 1'b1; tx_data = '1;
            chk("poke_tx_ready", tx_ready, 2'b00);
         end
         if (!cpha) for (int d = 0; d < 2; d++) seen[d][d ? k : W-1-k] = mosi[d];
         tick;
         lead = 1'b0; trail = 1'b0; tx_valid = 1'b0;
         if (cpha) for (int d = 0; d < 2; d++) miso[d] = sbit(slv, k, d);
         repeat ($urandom_range(0, 2)) tick;
         trail = 1'b1;
         if (cpha) for (int d = 0; d < 2; d++) seen[d][d ? k : W-1-k] = mosi[d];
         tick;
         trail = 1'b0;
         if (!cpha && k < W-1) for (int d = 0; d < 2; d++) miso[d] = sbit(slv, k+1, d);
         if (abort_k == k + 1) begin
            rst = 1'b1;
            tick;
            rst = 1'b0;
            chk("abort_ss_n", ss_n, 2'b11);
            chk("abort_mosi", mosi, 2'b00);
            chk("abort_busy", busy, 2'b00);
            chk("abort_tx_ready", tx_ready, 2'b11);
            chk("abort_rx_data0", rx_data[0], 0);
            repeat (3) tick;
            for (int d = 0; d < 2; d++) chk("abort_no_valid", vcnt[d] - v0[d], 0);
            return;
         end
      end
      chk("done_valid_low", rx_valid, 2'b00);
      chk("done_mosi_low", mosi, 2'b00);
      chk("done_ss_n", ss_n, lb ? 2'b11 : 2'b00);
      tick;
      chk("rx_valid_pulse", rx_valid, 2'b11);
      for (int d = 0; d < 2; d++) begin
         chk("rx_data", rx_data[d], exp_rx);
         chk("mosi_stream", seen[d], tx);
      end
      chk("end_ss_n", ss_n, 2'b11);
      chk("end_busy", busy, 2'b00);
      chk("end_tx_ready", tx_ready, 2'b11);
      tick;
      chk("rx_valid_one_cycle", rx_valid, 2'b00);
      for (int d = 0; d < 2; d++) chk("rx_valid_count", vcnt[d] - v0[d], 1);
   endtask

   task automatic idle_strobes(input int n);
      for (int i = 0; i < n; i++) begin
         lead = 1'($urandom); trail = 1'($urandom);
         tick;
         chk("idle_mosi", mosi, 2'b00);
         chk("idle_ss_n", ss_n, 2'b11);
      end
      lead = 1'b0; trail = 1'b0;
   endtask

   typedef struct {
      logic [1:0]   md;
      logic [W-1:0] tx;
      logic [W-1:0] slv;
      logic [W-1:0] exp_rx;
      bit           poke;
      bit           both;
   } vec_t;

   vec_t tbl [7];

   initial begin
      tbl[0] = '{SPI_MODE0, 8'hA5, 8'h3C, 8'h3C, 1'b0, 1'b0};
      tbl[1] = '{SPI_MODE1, 8'h81, 8'hF0, 8'hF0, 1'b0, 1'b0};
      tbl[2] = '{SPI_MODE0, 8'h01, 8'h80, 8'h80, 1'b0, 1'b0};
      tbl[3] = '{SPI_MODE0, 8'h55, 8'hAA, 8'hAA, 1'b1, 1'b0};
      tbl[4] = '{SPI_MODE2, 8'h0F, 8'hE1, 8'hE1, 1'b0, 1'b1};
      tbl[5] = '{SPI_MODE3, 8'hC3, 8'h5A, 8'h5A, 1'b1, 1'b1};
      tbl[6] = '{SPI_MODE1, 8'h7E, 8'h81, 8'h81, 1'b0, 1'b1};

      repeat (3) tick;
      rst = 1'b0;
      chk("reset_tx_ready", tx_ready, 2'b11);
      chk("reset_ss_n", ss_n, 2'b11);
      chk("reset_mosi", mosi, 2'b00);
      chk("reset_rx_valid", rx_valid, 2'b00);
      chk("reset_busy", busy, 2'b00);
      for (int d = 0; d < 2; d++) chk("reset_rx_data", rx_data[d], 0);

      foreach (tbl[i]) begin
         idle_strobes(2);
         xfer(tbl[i].md, tbl[i].tx, tbl[i].slv, tbl[i].exp_rx, tbl[i].poke, tbl[i].both, 0);
      end

      xfer(SPI_MODE0, 8'h96, 8'h69, 8'h69, 1'b0, 1'b0, 4);
      xfer(SPI_MODE0, 8'h3C, 8'hA5, 8'hA5, 1'b0, 1'b0, 0);
      xfer(SPI_MODE3, 8'h5A, 8'h33, 8'h33, 1'b0, 1'b0, 6);
      xfer(SPI_MODE1, 8'hE7, 8'h18, 8'h18, 1'b0, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] t, s;
         t = W'($urandom);
         s = W'($urandom);
         idle_strobes($urandom_range(0, 3));
         xfer(2'($urandom), t, s, s, 1'($urandom), 1'($urandom), 0);
      end

`ifdef SPI_M_LOOPBACK_EN
      lb = 1'b1;
      xfer(SPI_MODE0, 8'hC3, 8'h00, 8'hC3, 1'b0, 1'b0, 0);
      xfer(SPI_MODE3, 8'h96, 8'hFF, 8'h96, 1'b0, 1'b0, 0);
      lb = 1'b0;
      xfer(SPI_MODE0, 8'h24, 8'hDB, 8'hDB, 1'b0, 1'b0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end

endmodule

// File: doc/spi_m_shift.md
Name: spi_m_shift

Overview:
- Master-side SPI data path sitting directly downstream of the SPI master clock generator.
- Consumes its one-cycle leading/trailing edge strobes; serialises a TX word onto MOSI and deserialises MISO into an RX word per SPI mode (CPOL/CPHA).
- Owns slave-select and the byte-level host handshake.
- SCLK itself is generated upstream; this block never toggles it.

Parameters:
- DATA_W, 8, bits per transfer (>=2)
- MSB_FIRST, 1, 1 = MSB shifted first on MOSI and MISO; 0 = LSB first

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_mode  in  2  SPI mode; bit0 = CPHA, bit1 = CPOL; latched at transfer accept
- i_tx_valid  in  1  host requests transfer of i_tx_data
- i_tx_data  in  DATA_W  word to transmit
- o_tx_ready  out  1  high in IDLE only; accept = i_tx_valid & o_tx_ready
- i_leading_edge  in  1  one-cycle strobe from clock generator, first SCLK edge of each bit period
- i_trailing_edge  in  1  one-cycle strobe, second SCLK edge of each bit period
- i_miso  in  1  serial data from slave, already synchronised to i_clk
- o_mosi  out  1  serial data to slave
- o_ss_n  out  1  active-low slave select
- o_rx_data  out  DATA_W  last received word; held until next completion
- o_rx_valid  out  1  one-cycle pulse, o_rx_data updated
- o_busy  out  1  high from accept until return to IDLE

Behaviour:
- Reset (sync, i_rst=1 at posedge i_clk): state IDLE, o_ss_n=1, o_mosi=0, o_rx_data=0, o_rx_valid=0, o_busy=0, o_tx_ready=1, bit counter 0, shift registers 0. Reset mid-transfer aborts immediately; no o_rx_valid.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: edge strobes ignored. On accept: load tx shift register from i_tx_data, latch CPHA, clear rx register and bit counter, o_ss_n<=0, o_busy<=1, go to SHIFT.
  - CPHA=0: o_mosi presents first bit the cycle after accept.
  - CPHA=1: o_mosi held 0 until first leading strobe.
- SHIFT, CPHA=0:
  - Leading strobe: sample i_miso into rx register; bit_cnt+1.
  - Trailing strobe: if bit_cnt<DATA_W, advance tx register (next bit on o_mosi next cycle); else go to DONE.
- SHIFT, CPHA=1:
  - Leading strobe: drive next tx bit on o_mosi (first leading drives first bit).
  - Trailing strobe: sample i_miso; bit_cnt+1; if new bit_cnt==DATA_W go to DONE.
- Bit counter width is $clog2(DATA_W+1). It never wraps; it saturates logic-wise because the FSM leaves SHIFT.
- DONE lasts one cycle:
  - o_rx_data<=rx register (bit order per MSB_FIRST), o_rx_valid=1.
  - o_ss_n<=1, o_busy<=0 next cycle; go to IDLE.
  - o_mosi returns to 0.
- Latency: o_rx_valid asserted 2 cycles after the final trailing strobe (cycle N strobe, cycle N+1 DONE registered, output visible N+1 to N+2 window); exactly one cycle wide.
- i_tx_valid while busy: ignored, not queued.
- Simultaneous leading and trailing strobes (illegal upstream): leading processed, trailing ignored.
- i_mode changes mid-transfer: ignored until next accept.
- CPOL affects only the clock generator; this block uses CPOL for no decision beyond latching.

Optional Feature:
- Macro SPI_M_LOOPBACK_EN.
- Defined: adds input i_loopback. When 1, the sampled bit is o_mosi instead of i_miso, and o_ss_n stays 1 (slave not selected).
- Undefined: port absent; sampling always from i_miso.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE/SHIFT/DONE)
  - mode constants SPI_MODE0..3
  - CPHA/CPOL bit index constants
- One natural sub-module, spi_shift_reg: parameterised DATA_W bidirectional-order shift register with load, shift-enable and serial in/out. Instantiated twice, for TX and RX.

Test Plan:
- Mode 0, tx 0xA5, slave model returns 0x3C: MOSI sampled at each leading strobe = 1,0,1,0,0,1,0,1; o_rx_data=0x3C; o_rx_valid one pulse; o_ss_n low only during transfer.
- Mode 1, tx 0x81, slave returns 0xF0: MOSI changes only on leading strobes; o_rx_data=0xF0.
- MSB_FIRST=0, mode 0, tx 0x01: first MOSI bit 1, rest 0; slave LSB-first 0x80 gives o_rx_data=0x80.
- i_tx_valid pulsed with 0xFF during a 0x55 transfer: MOSI stream remains 0x55; only one o_rx_valid; o_tx_ready stays 0 until IDLE.
- i_rst asserted after 4th strobe pair: next cycle o_ss_n=1, o_mosi=0, o_busy=0, no o_rx_valid; new transfer 0x3C then completes normally.
- SPI_M_LOOPBACK_EN with i_loopback=1, tx 0xC3, any i_miso: o_rx_data=0xC3, o_ss_n held 1.
